// File: rtl/wb_load_formatter.sv
// wb_load_formatter: writeback-stage formatter for ALU results and loads.
// Issues word-aligned reads, extracts the addressed field and sign/zero
// extends it, then presents the result on a valid/ready writeback port.
// Optional macro MISALIGN_EN: loads crossing a word boundary are served by
// two reads (WAIT_HI state); without it such loads report wb_err instead.
module wb_load_formatter #(
  parameter int          XLEN    = 32,
  parameter logic [31:0] HC_ADDR = 32'hFFFF_FF00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_load,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [4:0]      in_rd,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic [XLEN-1:0] hc_data,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_err
);

  localparam int W    = XLEN / 8;
  localparam int OFFW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_LO = 2'd1,
`ifdef MISALIGN_EN
    S_WAIT_HI = 2'd2,
`endif
    S_OUT     = 2'd3
  } state_t;

  // Keep the low bytes of an already-shifted word, then sign or zero extend.
  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] raw,
                                               input logic [1:0]      size,
                                               input logic            uns);
    logic [XLEN-1:0] mask;
    logic            sgn;
    case (size)
      2'd0:    begin mask = XLEN'(8'hFF);         sgn = raw[7];      end
      2'd1:    begin mask = XLEN'(16'hFFFF);      sgn = raw[15];     end
      2'd2:    begin mask = XLEN'(32'hFFFF_FFFF); sgn = raw[31];     end
      default: begin mask = {XLEN{1'b1}};         sgn = raw[XLEN-1]; end
    endcase
    if (!uns && sgn) begin
      fmt_load = raw | ~mask;
    end else begin
      fmt_load = raw & mask;
    end
  endfunction

  state_t          r_state, w_state_next;
  logic [1:0]      r_size, w_size_next;
  logic            r_unsigned, w_unsigned_next;
  logic [OFFW-1:0] r_off, w_off_next;
  logic [4:0]      r_rd, w_rd_next;
  logic [XLEN-1:0] r_wb_data, w_wb_data_next;
  logic            r_mem_req_valid, w_mem_req_valid_next;
  logic [XLEN-1:0] r_mem_req_addr, w_mem_req_addr_next;
`ifdef MISALIGN_EN
  logic [XLEN-1:0] r_lo, w_lo_next;
  logic            r_cross, w_cross_next;
`else
  logic            r_wb_err, w_wb_err_next;
`endif

  logic            w_accept;
  logic [1:0]      w_size_eff;
  logic [OFFW-1:0] w_off;
  logic [4:0]      w_nbytes;
  logic            w_cross;
  logic            w_is_hc;
  logic [XLEN-1:0] w_word_addr;
  logic [OFFW+2:0] w_shamt;

  assign in_ready    = (r_state == S_IDLE) || ((r_state == S_OUT) && wb_ready);
  assign w_accept    = in_valid && in_ready;
  // A doubleword request on a 32-bit datapath degrades to a word access.
  assign w_size_eff  = ((XLEN == 32) && (in_size == 2'd3)) ? 2'd2 : in_size;
  assign w_off       = in_addr[OFFW-1:0];
  assign w_nbytes    = 5'd1 << w_size_eff;
  assign w_cross     = (5'(w_off) + w_nbytes) > 5'(W);
  assign w_is_hc     = (in_addr == XLEN'(HC_ADDR)) && (w_size_eff == 2'd2);
  assign w_word_addr = {in_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign w_shamt     = {r_off, 3'b000};

  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_mem_req_addr;
  assign wb_valid      = (r_state == S_OUT);
  assign wb_data       = r_wb_data;
  assign wb_rd         = r_rd;
`ifdef MISALIGN_EN
  assign wb_err        = 1'b0;
`else
  assign wb_err        = r_wb_err;
`endif

  // Next-state and datapath decode; a new accept overrides the state action.
  always_comb begin
    w_state_next         = r_state;
    w_size_next          = r_size;
    w_unsigned_next      = r_unsigned;
    w_off_next           = r_off;
    w_rd_next            = r_rd;
    w_wb_data_next       = r_wb_data;
    w_mem_req_valid_next = 1'b0;
    w_mem_req_addr_next  = r_mem_req_addr;
`ifdef MISALIGN_EN
    w_lo_next            = r_lo;
    w_cross_next         = r_cross;
`else
    w_wb_err_next        = r_wb_err;
`endif
    if (w_accept) begin
      w_rd_next       = in_rd;
      w_size_next     = w_size_eff;
      w_unsigned_next = in_unsigned;
      w_off_next      = w_off;
`ifndef MISALIGN_EN
      w_wb_err_next   = 1'b0;
`endif
      if (!in_is_load) begin
        w_wb_data_next = in_alu_result;
        w_state_next   = S_OUT;
      end else if (w_is_hc) begin
        w_wb_data_next = fmt_load(hc_data, 2'd2, in_unsigned);
        w_state_next   = S_OUT;
`ifndef MISALIGN_EN
      end else if (w_cross) begin
        w_wb_data_next = {XLEN{1'b0}};
        w_wb_err_next  = 1'b1;
        w_state_next   = S_OUT;
`endif
      end else begin
        w_mem_req_valid_next = 1'b1;
        w_mem_req_addr_next  = w_word_addr;
`ifdef MISALIGN_EN
        w_cross_next         = w_cross;
`endif
        w_state_next         = S_WAIT_LO;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = S_IDLE;
        end
        S_WAIT_LO: begin
          if (mem_rsp_valid) begin
`ifdef MISALIGN_EN
            w_lo_next = mem_rsp_data;
            if (r_cross) begin
              w_mem_req_valid_next = 1'b1;
              w_mem_req_addr_next  = r_mem_req_addr + XLEN'(W);
              w_state_next         = S_WAIT_HI;
            end else begin
              w_wb_data_next = fmt_load(mem_rsp_data >> w_shamt, r_size, r_unsigned);
              w_state_next   = S_OUT;
            end
`else
            w_wb_data_next = fmt_load(mem_rsp_data >> w_shamt, r_size, r_unsigned);
            w_state_next   = S_OUT;
`endif
          end else begin
            w_state_next = S_WAIT_LO;
          end
        end
`ifdef MISALIGN_EN
        S_WAIT_HI: begin
          if (mem_rsp_valid) begin
            w_wb_data_next = fmt_load(XLEN'({mem_rsp_data, r_lo} >> w_shamt),
                                      r_size, r_unsigned);
            w_state_next   = S_OUT;
          end else begin
            w_state_next = S_WAIT_HI;
          end
        end
`endif
        S_OUT: begin
          if (wb_ready) begin
            w_state_next  = S_IDLE;
`ifndef MISALIGN_EN
            w_wb_err_next = 1'b0;
`endif
          end else begin
            w_state_next = S_OUT;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset discards any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_size          <= 2'd0;
      r_unsigned      <= 1'b0;
      r_off           <= {OFFW{1'b0}};
      r_rd            <= 5'd0;
      r_wb_data       <= {XLEN{1'b0}};
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= {XLEN{1'b0}};
`ifdef MISALIGN_EN
      r_lo            <= {XLEN{1'b0}};
      r_cross         <= 1'b0;
`else
      r_wb_err        <= 1'b0;
`endif
    end else begin
      r_state         <= w_state_next;
      r_size          <= w_size_next;
      r_unsigned      <= w_unsigned_next;
      r_off           <= w_off_next;
      r_rd            <= w_rd_next;
      r_wb_data       <= w_wb_data_next;
      r_mem_req_valid <= w_mem_req_valid_next;
      r_mem_req_addr  <= w_mem_req_addr_next;
`ifdef MISALIGN_EN
      r_lo            <= w_lo_next;
      r_cross         <= w_cross_next;
`else
      r_wb_err        <= w_wb_err_next;
`endif
    end
  end

endmodule

// File: tb/tb_wb_load_formatter.sv
// Self-checking bench for wb_load_formatter: a 32-bit instance with a
// memory responder plus a 64-bit instance driven directly.
module tb_wb_load_formatter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 32-bit instance signals
  logic        in_valid, in_ready, in_is_load, in_unsigned;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_alu_result, hc_data;
  logic [4:0]  in_rd, wb_rd;
  logic        mem_req_valid, mem_rsp_valid, wb_valid, wb_ready, wb_err;
  logic [31:0] mem_req_addr, mem_rsp_data, wb_data;

  // 64-bit instance signals
  logic        d_in_valid, d_in_ready, d_in_is_load, d_in_unsigned;
  logic [1:0]  d_in_size;
  logic [63:0] d_in_addr, d_in_alu_result, d_hc_data;
  logic [4:0]  d_in_rd, d_wb_rd;
  logic        d_mem_req_valid, d_mem_rsp_valid, d_wb_valid, d_wb_ready, d_wb_err;
  logic [63:0] d_mem_req_addr, d_mem_rsp_data, d_wb_data;

  wb_load_formatter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_addr(in_addr), .in_alu_result(in_alu_result), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .hc_data(hc_data), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_err(wb_err));

  wb_load_formatter #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_is_load(d_in_is_load), .in_size(d_in_size), .in_unsigned(d_in_unsigned),
    .in_addr(d_in_addr), .in_alu_result(d_in_alu_result), .in_rd(d_in_rd),
    .mem_req_valid(d_mem_req_valid), .mem_req_addr(d_mem_req_addr),
    .mem_rsp_valid(d_mem_rsp_valid), .mem_rsp_data(d_mem_rsp_data),
    .hc_data(d_hc_data), .wb_valid(d_wb_valid), .wb_ready(d_wb_ready),
    .wb_data(d_wb_data), .wb_rd(d_wb_rd), .wb_err(d_wb_err));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed { logic [31:0] data; logic [4:0] rd; logic err; } exp_t;
  typedef struct packed { logic [1:0] size; logic uns; logic [31:0] addr;
                          logic [31:0] mem; logic [31:0] exp; } ld_t;
  typedef struct packed { logic [1:0] size; logic uns; logic [63:0] addr;
                          logic [63:0] mem; logic [63:0] exp; } ld64_t;

  exp_t        sb[$];
  logic [63:0] sb64[$];
  logic [31:0] rsp_q[$];
  logic [31:0] req_log[$];
  int          rsp_idx = 0;
  logic        rsp_en = 1'b1;
  logic        rsp_v = 1'b0;
  logic [31:0] rsp_d = 32'h0;
  logic        late_v = 1'b0;
  logic [31:0] late_d = 32'h0;
  ld_t         tbl[7];
  ld64_t       tbl64[5];

  assign mem_rsp_valid = rsp_v | late_v;
  assign mem_rsp_data  = rsp_v ? rsp_d : late_d;

  // Memory model: log every read request and answer it a cycle later from rsp_q.
  always begin
    @(negedge clk);
    if (mem_req_valid) begin
      req_log.push_back(mem_req_addr);
      if (rsp_en) begin
        @(posedge clk); #1;
        rsp_v = 1'b1;
        if (rsp_idx < rsp_q.size()) rsp_d = rsp_q[rsp_idx];
        else rsp_d = 32'h0;
        rsp_idx++;
        @(posedge clk); #1;
        rsp_v = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_wb(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!ok) begin
        if (wb_valid) ok = 1'b1;
        else tick();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_is_load = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
    in_addr = 32'h0; in_alu_result = 32'h0; in_rd = 5'd0; hc_data = 32'h0; wb_ready = 1'b1;
    d_in_valid = 1'b0; d_in_is_load = 1'b0; d_in_size = 2'd0; d_in_unsigned = 1'b0;
    d_in_addr = 64'h0; d_in_alu_result = 64'h0; d_in_rd = 5'd0; d_hc_data = 64'h0;
    d_wb_ready = 1'b1; d_mem_rsp_valid = 1'b0; d_mem_rsp_data = 64'h0;
    repeat (3) tick();
    rst = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    n_cmp++;
    if ({mem_req_valid, wb_valid, wb_err} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got req/valid/err=%b want 000", {mem_req_valid, wb_valid, wb_err});
    end
    n_cmp++;
    if (wb_data !== 32'h0 || wb_rd !== 5'd0) begin
      n_bad++; $display("FAIL reset_data: got %h/%0d want 0/0", wb_data, wb_rd);
    end
    n_cmp++;
    if (d_wb_valid !== 1'b0 || d_wb_data !== 64'h0 || d_in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_x64: got valid=%b data=%h ready=%b want 0/0/1", d_wb_valid, d_wb_data, d_in_ready);
    end
  endtask

  task automatic test_alu();
    exp_t e;
    in_valid = 1'b1; in_is_load = 1'b0; in_alu_result = 32'h1234_5678; in_rd = 5'd3; wb_ready = 1'b1;
    sb.push_back('{32'h1234_5678, 5'd3, 1'b0});
    tick();
    in_valid = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_data !== e.data || wb_rd !== e.rd) begin
      n_bad++; $display("FAIL alu_latency1: got v=%b %h rd=%0d want 1 %h rd=%0d", wb_valid, wb_data, wb_rd, e.data, e.rd);
    end
    tick();
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_bad++; $display("FAIL alu_retire: got wb_valid=%b want 0", wb_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals[4];
    exp_t e;
    vals[0] = 32'h0000_0001; vals[1] = 32'hFFFF_FFFF; vals[2] = 32'hA5A5_5A5A; vals[3] = 32'h8000_0000;
    in_valid = 1'b1; in_is_load = 1'b0; wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_alu_result = vals[i]; in_rd = 5'(10 + i);
      sb.push_back('{vals[i], 5'(10 + i), 1'b0});
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++; $display("FAIL b2b_ready: req %0d got in_ready=%b want 1", i, in_ready);
      end
      tick();
      e = sb.pop_front();
      n_cmp++;
      if (wb_valid !== 1'b1 || wb_data !== e.data || wb_rd !== e.rd) begin
        n_bad++; $display("FAIL b2b_result: req %0d got v=%b %h rd=%0d want 1 %h rd=%0d", i, wb_valid, wb_data, wb_rd, e.data, e.rd);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_loads();
    int   base;
    bit   ok;
    exp_t e;
    tbl[0] = '{2'd0, 1'b0, 32'h0000_0103, 32'h80AB_CDEF, 32'hFFFF_FF80};
    tbl[1] = '{2'd0, 1'b1, 32'h0000_0103, 32'h80AB_CDEF, 32'h0000_0080};
    tbl[2] = '{2'd1, 1'b0, 32'h0000_0102, 32'h8001_1234, 32'hFFFF_8001};
    tbl[3] = '{2'd1, 1'b1, 32'h0000_0100, 32'h8001_F234, 32'h0000_F234};
    tbl[4] = '{2'd2, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[5] = '{2'd3, 1'b0, 32'h0000_0108, 32'hCAFE_F00D, 32'hCAFE_F00D};
    tbl[6] = '{2'd0, 1'b0, 32'h0000_0101, 32'h0000_7F00, 32'h0000_007F};
    wb_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      base = req_log.size();
      rsp_q.push_back(tbl[i].mem);
      sb.push_back('{tbl[i].exp, 5'(i + 1), 1'b0});
      in_valid = 1'b1; in_is_load = 1'b1; in_size = tbl[i].size; in_unsigned = tbl[i].uns;
      in_addr = tbl[i].addr; in_rd = 5'(i + 1);
      tick();
      in_valid = 1'b0; in_is_load = 1'b0;
      wait_wb(ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok) begin
        n_bad++; $display("FAIL load_timeout: entry %0d got no wb_valid want result %h", i, e.data);
      end else if (wb_data !== e.data || wb_rd !== e.rd || wb_err !== e.err) begin
        n_bad++; $display("FAIL load_data: entry %0d got %h rd=%0d err=%b want %h rd=%0d err=%b", i, wb_data, wb_rd, wb_err, e.data, e.rd, e.err);
      end
      n_cmp++;
      if (req_log.size() != base + 1) begin
        n_bad++; $display("FAIL load_req_count: entry %0d got %0d reads want 1", i, req_log.size() - base);
      end else if (req_log[base] !== (tbl[i].addr & 32'hFFFF_FFFC)) begin
        n_bad++; $display("FAIL load_req_addr: entry %0d got %h want %h", i, req_log[base], tbl[i].addr & 32'hFFFF_FFFC);
      end
      tick();
    end
  endtask

  task automatic test_hc();
    int   base;
    exp_t e;
    base = req_log.size();
    hc_data = 32'd42;
    sb.push_back('{32'd42, 5'd20, 1'b0});
    in_valid = 1'b1; in_is_load = 1'b1; in_size = 2'd2; in_unsigned = 1'b0;
    in_addr = 32'hFFFF_FF00; in_rd = 5'd20; wb_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_is_load = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_data !== e.data || wb_rd !== e.rd) begin
      n_bad++; $display("FAIL hc_latency1: got v=%b %h rd=%0d want 1 %h rd=%0d", wb_valid, wb_data, wb_rd, e.data, e.rd);
    end
    tick(); tick();
    n_cmp++;
    if (req_log.size() != base) begin
      n_bad++; $display("FAIL hc_no_mem_req: got %0d reads want 0", req_log.size() - base);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    wb_ready = 1'b0;
    in_valid = 1'b1; in_is_load = 1'b0; in_alu_result = 32'hA5A5_5A5A; in_rd = 5'd9;
    sb.push_back('{32'hA5A5_5A5A, 5'd9, 1'b0});
    tick();
    in_alu_result = 32'h0BAD_F00D; in_rd = 5'd11;
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({wb_valid, in_ready} !== 2'b10 || wb_data !== e.data || wb_rd !== e.rd) begin
        n_bad++; $display("FAIL stall_hold: cycle %0d got v=%b rdy=%b %h rd=%0d want 1 0 %h rd=%0d", k, wb_valid, in_ready, wb_data, wb_rd, e.data, e.rd);
      end
      tick();
    end
    wb_ready = 1'b1;
    sb.push_back('{32'h0BAD_F00D, 5'd11, 1'b0});
    tick();
    in_valid = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_data !== e.data || wb_rd !== e.rd) begin
      n_bad++; $display("FAIL stall_next: got v=%b %h rd=%0d want 1 %h rd=%0d", wb_valid, wb_data, wb_rd, e.data, e.rd);
    end
    tick();
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_bad++; $display("FAIL stall_drain: got wb_valid=%b want 0", wb_valid);
    end
  endtask

`ifdef MISALIGN_EN
  task automatic test_misalign();
    int   base;
    bit   ok;
    exp_t e;
    base = req_log.size();
    rsp_q.push_back(32'hAABB_CCDD);
    rsp_q.push_back(32'h1122_3344);
    sb.push_back('{32'h3344_AABB, 5'd13, 1'b0});
    in_valid = 1'b1; in_is_load = 1'b1; in_size = 2'd2; in_unsigned = 1'b0;
    in_addr = 32'h0000_0102; in_rd = 5'd13; wb_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_is_load = 1'b0;
    wait_wb(ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL cross_timeout: got no wb_valid want %h", e.data);
    end else if (wb_data !== e.data || wb_rd !== e.rd || wb_err !== 1'b0) begin
      n_bad++; $display("FAIL cross_data: got %h rd=%0d err=%b want %h rd=%0d err=0", wb_data, wb_rd, wb_err, e.data, e.rd);
    end
    n_cmp++;
    if (req_log.size() != base + 2) begin
      n_bad++; $display("FAIL cross_req_count: got %0d reads want 2", req_log.size() - base);
    end else if (req_log[base] !== 32'h100 || req_log[base + 1] !== 32'h104) begin
      n_bad++; $display("FAIL cross_req_addr: got %h,%h want 00000100,00000104", req_log[base], req_log[base + 1]);
    end
    tick();
  endtask
`else
  task automatic test_misalign();
    int   base;
    exp_t e;
    base = req_log.size();
    sb.push_back('{32'h0, 5'd14, 1'b1});
    in_valid = 1'b1; in_is_load = 1'b1; in_size = 2'd1; in_unsigned = 1'b0;
    in_addr = 32'h0000_0103; in_rd = 5'd14; wb_ready = 1'b1;
    tick();
    in_is_load = 1'b0; in_alu_result = 32'h0000_0055; in_rd = 5'd15;
    e = sb.pop_front();
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_data !== e.data || wb_rd !== e.rd || wb_err !== e.err) begin
      n_bad++; $display("FAIL misalign_err: got v=%b %h rd=%0d err=%b want 1 %h rd=%0d err=%b", wb_valid, wb_data, wb_rd, wb_err, e.data, e.rd, e.err);
    end
    sb.push_back('{32'h0000_0055, 5'd15, 1'b0});
    tick();
    in_valid = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_data !== e.data || wb_rd !== e.rd || wb_err !== e.err) begin
      n_bad++; $display("FAIL misalign_err_clear: got v=%b %h rd=%0d err=%b want 1 %h rd=%0d err=%b", wb_valid, wb_data, wb_rd, wb_err, e.data, e.rd, e.err);
    end
    tick();
    n_cmp++;
    if (req_log.size() != base) begin
      n_bad++; $display("FAIL misalign_no_req: got %0d reads want 0", req_log.size() - base);
    end
  endtask
`endif

  task automatic test_reset_midop();
    int base;
    bit seen;
    rsp_en = 1'b0;
    base = req_log.size();
    in_valid = 1'b1; in_is_load = 1'b1; in_size = 2'd0; in_unsigned = 1'b0;
    in_addr = 32'h0000_0200; in_rd = 5'd12; wb_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_is_load = 1'b0;
    tick();
    n_cmp++;
    if (req_log.size() != base + 1) begin
      n_bad++; $display("FAIL rst_req_issued: got %0d reads want 1", req_log.size() - base);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    late_v = 1'b1; late_d = 32'h7777_7777;
    tick();
    late_v = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (wb_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    n_cmp++;
    if (seen) begin
      n_bad++; $display("FAIL rst_late_rsp: got wb_valid=1 after reset want 0");
    end
    n_cmp++;
    if (in_ready !== 1'b1 || wb_data !== 32'h0 || wb_rd !== 5'd0) begin
      n_bad++; $display("FAIL rst_clear: got rdy=%b %h rd=%0d want 1 0 0", in_ready, wb_data, wb_rd);
    end
    rsp_en = 1'b1;
  endtask

  task automatic test_xlen64();
    logic [63:0] e64;
    tbl64[0] = '{2'd2, 1'b1, 64'h4, 64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF};
    tbl64[1] = '{2'd2, 1'b0, 64'h4, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl64[2] = '{2'd3, 1'b0, 64'h8, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    tbl64[3] = '{2'd1, 1'b0, 64'h6, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0123};
    tbl64[4] = '{2'd0, 1'b0, 64'hF, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80};
    d_wb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d_in_valid = 1'b1; d_in_is_load = 1'b1; d_in_size = tbl64[i].size;
      d_in_unsigned = tbl64[i].uns; d_in_addr = tbl64[i].addr; d_in_rd = 5'(16 + i);
      sb64.push_back(tbl64[i].exp);
      tick();
      d_in_valid = 1'b0; d_in_is_load = 1'b0;
      n_cmp++;
      if (d_mem_req_valid !== 1'b1 || d_mem_req_addr !== (tbl64[i].addr & ~64'h7)) begin
        n_bad++; $display("FAIL x64_req: entry %0d got v=%b %h want 1 %h", i, d_mem_req_valid, d_mem_req_addr, tbl64[i].addr & ~64'h7);
      end
      tick();
      d_mem_rsp_valid = 1'b1; d_mem_rsp_data = tbl64[i].mem;
      tick();
      d_mem_rsp_valid = 1'b0;
      e64 = sb64.pop_front();
      n_cmp++;
      if (d_wb_valid !== 1'b1 || d_wb_data !== e64 || d_wb_rd !== 5'(16 + i)) begin
        n_bad++; $display("FAIL x64_data: entry %0d got v=%b %h rd=%0d want 1 %h rd=%0d", i, d_wb_valid, d_wb_data, d_wb_rd, e64, 16 + i);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_loads();
    test_hc();
    test_stall();
    test_misalign();
    test_reset_midop();
    test_xlen64();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_load_formatter.md
Name: wb_load_formatter

Overview:
- Parametrised successor to the writeback-stage load formatter.
- Accepts one writeback request per handshake: either an ALU result or a load. Issues the word-aligned memory read(s), extracts and sign/zero-extends the addressed field, and presents the result on a valid/ready writeback port.
- Generalised over XLEN (32/64, adds doubleword/unsigned-word loads).
- Adds a split two-beat FSM for loads that cross a word boundary, plus a hardware-counter bypass.

Parameters:
- XLEN, 32, datapath and memory word width; 32 or 64 only.
- HC_ADDR, 32'hFFFF_FF00, load address served from hc_data instead of memory.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_is_load  in  1  1 = load, 0 = pass in_alu_result
- in_size  in  2  0 byte, 1 half, 2 word, 3 double (XLEN=64 only)
- in_unsigned  in  1  zero-extend (LBU/LHU/LWU)
- in_addr  in  XLEN  load byte address
- in_alu_result  in  XLEN  non-load result
- in_rd  in  5  destination register, carried to wb_rd
- mem_req_valid  out  1  one-cycle read pulse
- mem_req_addr  out  XLEN  word-aligned read address
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  XLEN  read data
- hc_data  in  XLEN  hardware counter value
- wb_valid  out  1  result valid
- wb_ready  in  1  consumer accepts
- wb_data  out  XLEN  formatted result
- wb_rd  out  5  destination register
- wb_err  out  1  misaligned-load error (only without MISALIGN_EN)

Behaviour:
- Definitions:
  - Word size W = XLEN/8 bytes. Offset off = in_addr mod W. Access bytes n = 1 << in_size.
  - Crossing = off + n > W.
  - XLEN=32 with in_size=3 is treated as size 2.
- Reset: state IDLE. in_ready=1; mem_req_valid=0; wb_valid=0; wb_data=0; wb_rd=0; wb_err=0.
- Reset mid-operation discards all captured data. mem_rsp_valid outside WAIT_LO/WAIT_HI is ignored.
- FSM states: IDLE, WAIT_LO, WAIT_HI, OUT.
- in_ready = (state==IDLE) | (state==OUT & wb_ready). On accept, in_rd is latched.
- Accept, non-load: wb_data <= in_alu_result, next OUT. wb_valid rises the cycle after accept (latency 1).
- Accept, load with in_addr==HC_ADDR and size 2: wb_data <= hc_data formatted as a word load. No memory request; next OUT; latency 1.
- Accept, other load:
  - mem_req_valid=1 for exactly the next cycle, with mem_req_addr = in_addr with low log2(W) bits cleared.
  - Next state WAIT_LO.
- WAIT_LO, on mem_rsp_valid, capture lo:
  - If crossing: issue mem_req at word address + W (one-cycle pulse), next WAIT_HI.
  - Otherwise: format from lo, next OUT.
- WAIT_HI, on mem_rsp_valid: form the 2·XLEN concatenation {hi, lo}, shift right by off·8, format the low n bytes, next OUT.
- Formatting:
  - Field = n bytes at byte off.
  - Signed: replicate field MSB to XLEN. Unsigned: zero-fill.
  - Size equal to XLEN passes unchanged.
- OUT: wb_valid=1 and wb_data/wb_rd held stable until wb_ready.
  - On wb_ready with simultaneous in_valid, the new request is accepted the same cycle (back-to-back ALU throughput = 1 per cycle).
  - On wb_ready without in_valid, next IDLE and wb_valid=0.
- Little-endian byte order throughout.

Optional Feature:
- MISALIGN_EN defined: crossing loads take the two-read WAIT_HI path described above. wb_err tied 0.
- MISALIGN_EN undefined: WAIT_HI does not exist.
  - A crossing load is detected at accept. No mem_req is issued.
  - Next state OUT with wb_data=0 and wb_err=1.
  - wb_err clears when that result is accepted.

Test Plan:
- XLEN=32, ALU request in_alu_result=32'h1234_5678, wb_ready=1, in_valid held → wb_data=32'h1234_5678 one cycle after accept. Four back-to-back ALU requests complete in 4 consecutive cycles.
- LB addr 0x103, mem_rsp_data=32'h80AB_CDEF → single mem_req_addr=0x100, wb_data=32'hFFFF_FF80. The same request as LBU → 32'h0000_0080.
- MISALIGN_EN, LW addr 0x102:
  - Stimulus: lo=32'hAABB_CCDD, hi=32'h1122_3344.
  - Required: mem_req at 0x100 then 0x104, wb_data=32'h3344_AABB.
- LW at HC_ADDR, hc_data=32'd42 → no mem_req_valid, wb_data=42 one cycle after accept.
- wb_ready=0 for 5 cycles in OUT → wb_valid, wb_data and wb_rd stable, in_ready=0. rst asserted during WAIT_LO, then a late mem_rsp_valid arrives → no wb_valid.
- MISALIGN_EN undefined, LH addr 0x103 → no mem_req, wb_err=1, wb_data=0. XLEN=64, LWU addr 0x4, data 64'hFFFF_FFFF_0000_0000 → wb_data=64'h0000_0000_FFFF_FFFF.
